// File: rtl/signal_gen_pn_multi.sv
// signal_gen_pn_multi
// Multi-channel, multi-lane square-wave generator for the gate-drive path.
// Each clock produces LANES consecutive samples per channel. All channels
// share one period; each channel has its own phase offset. Period/phase
// writes are double-buffered and commit together at period rollover.
// Pipeline: counter stage -> aligned operand stage -> registered output word.
module signal_gen_pn_multi #(
   parameter int unsigned         LANES          = 16,
   parameter int unsigned         CHANNELS       = 2,
   parameter int unsigned         PERIOD_WIDTH   = 32,
   parameter int unsigned         PHASE_WIDTH    = 10,
   parameter int unsigned         INITIAL_PERIOD = 1600,
   parameter logic [CHANNELS-1:0] INVERT_MASK    = '0
) (
   input  logic                                              p_clock,
   input  logic                                              reset,
   input  logic                                              run,
   input  logic [PERIOD_WIDTH-1:0]                           period_in,
   input  logic                                              set_period,
   input  logic [PHASE_WIDTH-1:0]                            phase_in,
   input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] phase_sel,
   input  logic                                              set_phase,
   output logic [CHANNELS*LANES-1:0]                         p_out,
   output logic                                              running,
   output logic                                              rollover,
   output logic                                              pending,
   output logic                                              period_err
);

   localparam int unsigned SUMW = PERIOD_WIDTH + 2;
   localparam logic [PERIOD_WIDTH:0]   LANES_W       = (PERIOD_WIDTH + 1)'(LANES);
   localparam logic [PERIOD_WIDTH-1:0] MIN_PERIOD    = PERIOD_WIDTH'(2 * LANES);
   localparam logic [PERIOD_WIDTH-1:0] INIT_PERIOD_W = PERIOD_WIDTH'(INITIAL_PERIOD);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN      = 2'd1,
      ST_STOPPING = 2'd2
   } state_e;

   // ------------------------------------------------------------------
   // Reset synchroniser: assertion is immediate, release takes two edges
   // ------------------------------------------------------------------
   logic [1:0] rst_sync_q;
   logic       rst_n;

   // Two-flop release synchroniser for the external active-low reset
   always_ff @(posedge p_clock or negedge reset) begin
      if (!reset) begin
         rst_sync_q <= '0;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_n = rst_sync_q[1];

   // ------------------------------------------------------------------
   // Stage 0: control state, counter, active and shadow registers
   // ------------------------------------------------------------------
   state_e                                 state_q;
   logic [PERIOD_WIDTH-1:0]                cnt_q;
   logic [PERIOD_WIDTH-1:0]                per_q;
   logic [CHANNELS-1:0][PHASE_WIDTH-1:0]   ph_q;
   logic [PERIOD_WIDTH-1:0]                sh_per_q;
   logic [CHANNELS-1:0][PHASE_WIDTH-1:0]   sh_ph_q;
   logic                                   pending_q;
   logic                                   per_err_q;

   logic [PERIOD_WIDTH:0]                  adv_w;
   logic                                   roll_w;
   logic                                   stop_w;
   logic                                   per_ok_w;
   logic                                   sel_ok_w;
   logic                                   wr_w;
   logic                                   commit_w;
   logic                                   pending_d;
   logic [PERIOD_WIDTH-1:0]                cnt_d;

   // Counter advance, rollover detection, write acceptance and commit
   always_comb begin
      adv_w     = {1'b0, cnt_q} + LANES_W;
      roll_w    = (state_q != ST_IDLE) && (adv_w >= {1'b0, per_q});
      stop_w    = (state_q == ST_STOPPING) && !run && roll_w;
      per_ok_w  = (period_in >= MIN_PERIOD);
      sel_ok_w  = (32'(phase_sel) < CHANNELS);
      wr_w      = (set_period && per_ok_w) || (set_phase && sel_ok_w);
      // Commit uses the shadow as it stood before this edge, so a write
      // arriving in the commit cycle itself stays pending for the next one.
      commit_w  = pending_q && (roll_w || ((state_q == ST_IDLE) && run));
      if (wr_w) begin
         pending_d = 1'b1;
      end else if (commit_w) begin
         pending_d = 1'b0;
      end else begin
         pending_d = pending_q;
      end
      if ((state_q == ST_IDLE) || stop_w) begin
         cnt_d = '0;
      end else if (roll_w) begin
         cnt_d = PERIOD_WIDTH'(adv_w - {1'b0, per_q});
      end else begin
         cnt_d = PERIOD_WIDTH'(adv_w);
      end
   end

   // Run/stop FSM together with counter, active/shadow registers and flags
   always_ff @(posedge p_clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         per_q     <= INIT_PERIOD_W;
         ph_q      <= '0;
         // Shadow period mirrors the active one so a phase-only commit
         // never loads a meaningless period.
         sh_per_q  <= INIT_PERIOD_W;
         sh_ph_q   <= '0;
         pending_q <= 1'b0;
         per_err_q <= 1'b0;
      end else begin
         per_err_q <= set_period && !per_ok_w;
         pending_q <= pending_d;
         cnt_q     <= cnt_d;
         if (commit_w) begin
            per_q <= sh_per_q;
            ph_q  <= sh_ph_q;
         end
         if (set_period && per_ok_w) begin
            sh_per_q <= period_in;
         end
         if (set_phase && sel_ok_w) begin
            sh_ph_q[phase_sel] <= phase_in;
         end
         unique case (state_q)
            ST_IDLE: begin
               if (run) begin
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (!run) begin
                  state_q <= ST_STOPPING;
               end
            end
            ST_STOPPING: begin
               if (run) begin
                  state_q <= ST_RUN;
               end else if (roll_w) begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Stage 1: counter, period and offsets aligned to the same word
   // ------------------------------------------------------------------
   logic [PERIOD_WIDTH-1:0]                 c1_q;
   logic [PERIOD_WIDTH-1:0]                 p1_q;
   logic [CHANNELS-1:0][PERIOD_WIDTH-1:0]   off_q;
   logic                                    act1_q;
   logic                                    roll1_q;
   logic [CHANNELS-1:0][PERIOD_WIDTH-1:0]   off_d;

   // Phase offset per channel: full-width product scaled by phase full scale
   always_comb begin
      off_d = '0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
         off_d[c] = PERIOD_WIDTH'(((PERIOD_WIDTH + PHASE_WIDTH)'(ph_q[c]) *
                                   (PERIOD_WIDTH + PHASE_WIDTH)'(per_q)) >> PHASE_WIDTH);
      end
   end

   // Offsets are registered from the active values one cycle after they
   // change, which lines them up with the counter/period copied here, so
   // the straddling word keeps old values and the next word gets new ones.
   always_ff @(posedge p_clock or negedge rst_n) begin
      if (!rst_n) begin
         c1_q    <= '0;
         p1_q    <= INIT_PERIOD_W;
         off_q   <= '0;
         act1_q  <= 1'b0;
         roll1_q <= 1'b0;
      end else begin
         c1_q    <= cnt_q;
         p1_q    <= per_q;
         off_q   <= off_d;
         act1_q  <= (state_q != ST_IDLE);
         roll1_q <= roll_w;
      end
   end

   // ------------------------------------------------------------------
   // Stage 2: sample generation, inversion, idle gating
   // ------------------------------------------------------------------
   logic [CHANNELS*LANES-1:0] word_w;
   logic [CHANNELS*LANES-1:0] inv_w;
   logic [SUMW-1:0]           pos_w;
   logic [SUMW-1:0]           per_ext_w;
   logic [SUMW-1:0]           half_w;
   logic [CHANNELS*LANES-1:0] p_out_q;
   logic                      running_q;
   logic                      rollover_q;

   // Lane position modulo period (two conditional subtractions) vs half period
   always_comb begin
      word_w    = '0;
      inv_w     = '0;
      pos_w     = '0;
      per_ext_w = SUMW'(p1_q);
      half_w    = SUMW'(p1_q >> 1);
      for (int unsigned c = 0; c < CHANNELS; c++) begin
         inv_w[c*LANES +: LANES] = {LANES{INVERT_MASK[c]}};
         for (int unsigned k = 0; k < LANES; k++) begin
            pos_w = SUMW'(c1_q) + SUMW'(k) + SUMW'(off_q[c]);
            if (pos_w >= per_ext_w) begin
               pos_w = pos_w - per_ext_w;
            end
            if (pos_w >= per_ext_w) begin
               pos_w = pos_w - per_ext_w;
            end
            word_w[c*LANES + k] = (pos_w < half_w);
         end
      end
   end

   // Output register: inversion first, then forced low while idle
   always_ff @(posedge p_clock or negedge rst_n) begin
      if (!rst_n) begin
         p_out_q    <= '0;
         running_q  <= 1'b0;
         rollover_q <= 1'b0;
      end else begin
         p_out_q    <= act1_q ? (word_w ^ inv_w) : '0;
         running_q  <= act1_q;
         rollover_q <= roll1_q;
      end
   end

   assign p_out      = p_out_q;
   assign running    = running_q;
   assign rollover   = rollover_q;
   assign pending    = pending_q;
   assign period_err = per_err_q;

endmodule

// File: tb/tb_signal_gen_pn_multi.sv
// Directed bench for signal_gen_pn_multi: LANES=16, CHANNELS=2, channel 1
// inverted. Expected words are hand-computed from the waveform definition.
module tb_signal_gen_pn_multi;

   logic        p_clock = 1'b0;
   logic        reset;
   logic        run;
   logic [31:0] period_in;
   logic        set_period;
   logic [9:0]  phase_in;
   logic [0:0]  phase_sel;
   logic        set_phase;
   logic [31:0] p_out;
   logic        running;
   logic        rollover;
   logic        pending;
   logic        period_err;

   int total = 0;
   int bad   = 0;

   always #5 p_clock = ~p_clock;

   signal_gen_pn_multi #(
      .LANES          (16),
      .CHANNELS       (2),
      .PERIOD_WIDTH   (32),
      .PHASE_WIDTH    (10),
      .INITIAL_PERIOD (1600),
      .INVERT_MASK    (2'b10)
   ) dut (
      .p_clock    (p_clock),
      .reset      (reset),
      .run        (run),
      .period_in  (period_in),
      .set_period (set_period),
      .phase_in   (phase_in),
      .phase_sel  (phase_sel),
      .set_phase  (set_phase),
      .p_out      (p_out),
      .running    (running),
      .rollover   (rollover),
      .pending    (pending),
      .period_err (period_err)
   );

   task automatic tick();
      @(posedge p_clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_word(input string tag, input logic [31:0] w, input logic roll, input logic act);
      chk($sformatf("%s.p_out", tag), p_out, w);
      chk1($sformatf("%s.rollover", tag), rollover, roll);
      chk1($sformatf("%s.running", tag), running, act);
   endtask

   initial begin
      reset = 1'b0; run = 1'b0; set_period = 1'b0; set_phase = 1'b0;
      period_in = '0; phase_in = '0; phase_sel = '0;
      tick(); tick();
      chk_word("reset", 32'h0, 1'b0, 1'b0);
      chk1("reset.pending", pending, 1'b0);
      chk1("reset.period_err", period_err, 1'b0);

      reset = 1'b1;
      tick(); tick(); tick();

      // Program P=64 while idle; commits on the IDLE->RUN edge
      period_in = 32'd64; set_period = 1'b1; tick(); set_period = 1'b0;
      chk1("idle.pending", pending, 1'b1);
      chk("idle.p_out", p_out, 32'h0);

      run = 1'b1; tick();                        // t=0: C=0
      chk1("start.pending", pending, 1'b0);
      tick(); chk_word("b_pre", 32'h0, 1'b0, 1'b0);   // t=1
      tick(); chk_word("b0", 32'h0000FFFF, 1'b0, 1'b1);
      tick(); chk_word("b1", 32'h0000FFFF, 1'b0, 1'b1);
      tick(); chk_word("b2", 32'hFFFF0000, 1'b0, 1'b1);
      tick(); chk_word("b3", 32'hFFFF0000, 1'b1, 1'b1);
      tick(); chk_word("b4", 32'h0000FFFF, 1'b0, 1'b1);
      tick(); chk_word("b5", 32'h0000FFFF, 1'b0, 1'b1);
      tick(); chk_word("b6", 32'hFFFF0000, 1'b0, 1'b1);
      tick(); chk_word("b7", 32'hFFFF0000, 1'b1, 1'b1);   // t=9, C=16

      // Phase ch1 = 256 (quarter period) mid-period
      phase_sel = 1'b1; phase_in = 10'd256; set_phase = 1'b1;
      tick(); set_phase = 1'b0;                  // t=10
      chk1("ph.pending_set", pending, 1'b1);
      tick();                                    // t=11, rollover cycle
      chk1("ph.pending_hold", pending, 1'b1);
      chk_word("ph.old9", 32'h0000FFFF, 1'b0, 1'b1);
      tick();                                    // t=12, committed
      chk1("ph.pending_clr", pending, 1'b0);
      tick(); chk_word("ph.old11", 32'hFFFF0000, 1'b1, 1'b1);
      tick(); chk_word("ph.n0", 32'h0000FFFF, 1'b0, 1'b1);
      tick(); chk_word("ph.n1", 32'hFFFFFFFF, 1'b0, 1'b1);
      tick(); chk_word("ph.n2", 32'hFFFF0000, 1'b0, 1'b1);
      tick(); chk_word("ph.n3", 32'h00000000, 1'b1, 1'b1);   // t=17

      // Rejected period
      period_in = 32'd31; set_period = 1'b1; tick(); set_period = 1'b0;   // t=18
      chk1("rej.period_err", period_err, 1'b1);
      chk1("rej.pending", pending, 1'b0);
      chk_word("rej.w16", 32'h0000FFFF, 1'b0, 1'b1);
      tick();                                    // t=19, rollover cycle (C=48)
      chk1("rej.period_err_pulse", period_err, 1'b0);
      chk_word("rej.w17", 32'hFFFFFFFF, 1'b0, 1'b1);

      // Period 96 written on a rollover cycle: P=64 for one more period
      period_in = 32'd96; set_period = 1'b1; tick(); set_period = 1'b0;   // t=20
      chk1("wr.pending", pending, 1'b1);
      chk_word("wr.w18", 32'hFFFF0000, 1'b0, 1'b1);
      tick(); chk_word("wr.w19", 32'h00000000, 1'b1, 1'b1);
      tick(); chk_word("wr.w20", 32'h0000FFFF, 1'b0, 1'b1);
      tick(); chk_word("wr.w21", 32'hFFFFFFFF, 1'b0, 1'b1);
      chk1("wr.pending_hold", pending, 1'b1);
      tick(); chk_word("wr.w22", 32'hFFFF0000, 1'b0, 1'b1);
      chk1("wr.pending_clr", pending, 1'b0);
      tick(); chk_word("wr.w23", 32'h00000000, 1'b1, 1'b1);
      tick(); chk_word("p96.w0", 32'h0000FFFF, 1'b0, 1'b1);
      tick(); chk_word("p96.w1", 32'hFF00FFFF, 1'b0, 1'b1);
      tick(); chk_word("p96.w2", 32'hFFFFFFFF, 1'b0, 1'b1);
      tick(); chk_word("p96.w3", 32'hFFFF0000, 1'b0, 1'b1);
      tick(); chk_word("p96.w4", 32'h00FF0000, 1'b0, 1'b1);
      tick(); chk_word("p96.w5", 32'h00000000, 1'b1, 1'b1);   // t=31, C=16

      // Stop mid-period: runs to the period end, then drains to zero
      run = 1'b0;
      tick();                                    // t=32
      tick(); chk_word("stop.w31", 32'hFF00FFFF, 1'b0, 1'b1);
      tick(); chk_word("stop.w32", 32'hFFFFFFFF, 1'b0, 1'b1);
      tick(); chk_word("stop.w33", 32'hFFFF0000, 1'b0, 1'b1);
      tick(); chk_word("stop.w34", 32'h00FF0000, 1'b0, 1'b1);
      tick(); chk_word("stop.w35", 32'h00000000, 1'b1, 1'b1);
      tick(); chk_word("stop.idle", 32'h00000000, 1'b0, 1'b0);
      tick(); chk_word("stop.idle2", 32'h00000000, 1'b0, 1'b0);

      // Last write wins; period and phase in the same cycle both accepted
      period_in = 32'd48; set_period = 1'b1; tick();
      period_in = 32'd40; phase_sel = 1'b1; phase_in = 10'd0; set_phase = 1'b1;
      tick(); set_period = 1'b0; set_phase = 1'b0;
      chk1("p40.pending", pending, 1'b1);
      chk1("p40.period_err", period_err, 1'b0);

      run = 1'b1; tick();                        // t=0: C=0, P=40
      tick(); chk_word("p40.pre", 32'h0, 1'b0, 1'b0);
      tick(); chk_word("p40.w0", 32'h0000FFFF, 1'b0, 1'b1);
      tick(); chk_word("p40.w1", 32'hFFF0000F, 1'b0, 1'b1);
      tick(); chk_word("p40.w2", 32'h00FFFF00, 1'b1, 1'b1);
      tick(); chk_word("p40.w3", 32'hF0000FFF, 1'b0, 1'b1);
      tick(); chk_word("p40.w4", 32'hFFFF0000, 1'b1, 1'b1);
      tick(); chk_word("p40.w5", 32'h0000FFFF, 1'b0, 1'b1);

      // Asynchronous reset in the middle of a clock cycle
      #2 reset = 1'b0;
      #1;
      chk_word("areset", 32'h0, 1'b0, 1'b0);
      chk1("areset.pending", pending, 1'b0);
      run = 1'b0;
      tick(); tick();
      reset = 1'b1;
      tick(); tick();
      run = 1'b1; tick();                        // t=0, P back to 1600
      for (int i = 0; i < 51; i++) tick();       // t=51: word 49
      chk_word("p1600.w49", 32'h0000FFFF, 1'b0, 1'b1);
      tick();
      chk_word("p1600.w50", 32'hFFFF0000, 1'b0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
